fa_triple: RTL and testbench

Registered 1-bit full-adder block that computes sum and carry-out three independent ways: dataflow equations, behavioral arithmetic and a case-based truth table. All three results are registered and cross-checked every cycle. The block serves as the adder-equivalence unit in the logic-design practice datapath. Downstream logic reads any one result pair, or the mismatch status.

---
 rtl/fa_pkg.sv | 18 +
 rtl/fa_triple_if.sv | 29 ++
 rtl/fa_cell.sv | 48 ++++
 rtl/fa_triple.sv | 90 +++++++++
 tb/tb_fa_triple.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/fa_pkg.sv
// Shared constants and types for the triple-implementation full adder.
package fa_pkg;

    // Implementation selector values for fa_cell.
    localparam int STYLE_DATAFLOW = 0;
    localparam int STYLE_BEHAV    = 1;
    localparam int STYLE_CASE     = 2;

    // Default width of the saturating mismatch counter.
    localparam int CNT_W_DEFAULT = 8;

    // One adder result, carry in the upper bit so {co, s} reads as a 2-bit sum.
    typedef struct packed {
        logic co;
        logic s;
    } fa_pair_t;

endpackage : fa_pkg

// File: rtl/fa_triple_if.sv
// Bus between the adder-equivalence unit and its user: three input bits in,
// three registered result pairs plus mismatch status out.
interface fa_triple_if #(
    parameter int CNT_W = fa_pkg::CNT_W_DEFAULT
);
    logic             a;
    logic             b;
    logic             ci;
    logic             s1;
    logic             co1;
    logic             s2;
    logic             co2;
    logic             s3;
    logic             co3;
    logic             mismatch;
    logic [CNT_W-1:0] mismatch_cnt;

    // Driver of the operands and reader of the results.
    modport master (
        output a, b, ci,
        input  s1, co1, s2, co2, s3, co3, mismatch, mismatch_cnt
    );

    // The adder block itself.
    modport slave (
        input  a, b, ci,
        output s1, co1, s2, co2, s3, co3, mismatch, mismatch_cnt
    );
endinterface : fa_triple_if

// File: rtl/fa_cell.sv
// Purely combinational 1-bit full adder; STYLE picks which of three
// equivalent descriptions is elaborated.
module fa_cell
    import fa_pkg::*;
#(
    parameter int STYLE = STYLE_DATAFLOW
) (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    if (STYLE == STYLE_DATAFLOW) begin : g_dataflow
        assign s  = a ^ b ^ ci;
        assign co = (a & b) | (a & ci) | (b & ci);
    end else if (STYLE == STYLE_BEHAV) begin : g_behav
        logic [1:0] total;

        // Arithmetic sum of three bits; the upper bit is the carry.
        always_comb begin
            total = {1'b0, a} + {1'b0, b} + {1'b0, ci};
        end

        assign {co, s} = total;
    end else begin : g_case
        // Explicit truth table on {ci, a, b}.
        always_comb begin
            // NOTE: assign every output before the case so no path leaves it
            // unassigned; otherwise synthesis infers a latch.
            s  = 1'b0;
            co = 1'b0;
            case ({ci, a, b})
                3'b000:  begin s = 1'b0; co = 1'b0; end
                3'b001:  begin s = 1'b1; co = 1'b0; end
                3'b010:  begin s = 1'b1; co = 1'b0; end
                3'b100:  begin s = 1'b1; co = 1'b0; end
                3'b011:  begin s = 1'b0; co = 1'b1; end
                3'b101:  begin s = 1'b0; co = 1'b1; end
                3'b110:  begin s = 1'b0; co = 1'b1; end
                3'b111:  begin s = 1'b1; co = 1'b1; end
                default: begin s = 1'b0; co = 1'b0; end
            endcase
        end
    end

endmodule : fa_cell

// File: rtl/fa_triple.sv
// Adder-equivalence unit: three full-adder descriptions evaluated in
// parallel, results registered, and any disagreement flagged and counted.
module fa_triple
    import fa_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    fa_triple_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Raw cell outputs; kept as named nets so each result is observable.
    logic s_df, co_df;
    logic s_bh, co_bh;
    logic s_case, co_case;

    fa_pair_t pair_df, pair_bh, pair_case;
    logic     disagree;

    // Registered state.
    fa_pair_t         pair_df_q, pair_bh_q, pair_case_q;
    logic             mismatch_q;
    logic [CNT_W-1:0] cnt_q;

    fa_cell #(.STYLE(STYLE_DATAFLOW)) u_dataflow (
        .a  (bus.a),
        .b  (bus.b),
        .ci (bus.ci),
        .s  (s_df),
        .co (co_df)
    );

    fa_cell #(.STYLE(STYLE_BEHAV)) u_behav (
        .a  (bus.a),
        .b  (bus.b),
        .ci (bus.ci),
        .s  (s_bh),
        .co (co_bh)
    );

    fa_cell #(.STYLE(STYLE_CASE)) u_case (
        .a  (bus.a),
        .b  (bus.b),
        .ci (bus.ci),
        .s  (s_case),
        .co (co_case)
    );

    assign pair_df   = '{co: co_df,   s: s_df};
    assign pair_bh   = '{co: co_bh,   s: s_bh};
    assign pair_case = '{co: co_case, s: s_case};

    // Any pairwise inequality; two comparisons against one reference
    // cover all three pairs.
    assign disagree = (pair_df != pair_bh) || (pair_df != pair_case);

    // Result registers, mismatch flag and saturating counter; reset wins.
    always_ff @(posedge clk) begin
        // NOTE: registered state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            pair_df_q   <= '0;
            pair_bh_q   <= '0;
            pair_case_q <= '0;
            mismatch_q  <= 1'b0;
            cnt_q       <= '0;
        end else begin
            pair_df_q   <= pair_df;
            pair_bh_q   <= pair_bh;
            pair_case_q <= pair_case;
            mismatch_q  <= disagree;
            if (disagree && (cnt_q != CNT_MAX)) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign bus.s1           = pair_df_q.s;
    assign bus.co1          = pair_df_q.co;
    assign bus.s2           = pair_bh_q.s;
    assign bus.co2          = pair_bh_q.co;
    assign bus.s3           = pair_case_q.s;
    assign bus.co3          = pair_case_q.co;
    assign bus.mismatch     = mismatch_q;
    assign bus.mismatch_cnt = cnt_q;

endmodule : fa_triple

// File: tb/tb_fa_triple.sv
// Directed bench for fa_triple: truth-table sweep from a vector table, plus
// hand-written sequences for latency, fault injection, saturation and reset.
module tb_fa_triple;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    int n_cmp  = 0;
    int n_fail = 0;

    fa_triple_if #(.CNT_W(8)) bus8 ();
    fa_triple_if #(.CNT_W(2)) bus2 ();

    fa_triple #(.CNT_W(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8.slave)
    );

    fa_triple #(.CNT_W(2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] sel;   // {ci, a, b}
        logic       s;
        logic       co;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive the same operands into both instances.
    task automatic set_in(input logic [2:0] sel);
        bus8.ci = sel[2]; bus8.a = sel[1]; bus8.b = sel[0];
        bus2.ci = sel[2]; bus2.a = sel[1]; bus2.b = sel[0];
    endtask

    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare all outputs of the 8-bit instance.
    task automatic check8(input string tag, input logic s, input logic co,
                          input logic mm, input logic [7:0] cnt);
        check({tag, ".s1"},  32'(bus8.s1),  32'(s));
        check({tag, ".co1"}, 32'(bus8.co1), 32'(co));
        check({tag, ".s2"},  32'(bus8.s2),  32'(s));
        check({tag, ".co2"}, 32'(bus8.co2), 32'(co));
        check({tag, ".s3"},  32'(bus8.s3),  32'(s));
        check({tag, ".co3"}, 32'(bus8.co3), 32'(co));
        check({tag, ".mismatch"}, 32'(bus8.mismatch), 32'(mm));
        check({tag, ".cnt"}, 32'(bus8.mismatch_cnt), 32'(cnt));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{3'b000, 1'b0, 1'b0};
        vecs[1] = '{3'b001, 1'b1, 1'b0};
        vecs[2] = '{3'b010, 1'b1, 1'b0};
        vecs[3] = '{3'b011, 1'b0, 1'b1};
        vecs[4] = '{3'b100, 1'b1, 1'b0};
        vecs[5] = '{3'b101, 1'b0, 1'b1};
        vecs[6] = '{3'b110, 1'b0, 1'b1};
        vecs[7] = '{3'b111, 1'b1, 1'b1};

        // Reset held for two edges with all inputs high.
        rst_n = 1'b0;
        set_in(3'b111);
        tick();
        tick();
        check8("reset", 1'b0, 1'b0, 1'b0, 8'd0);
        check("reset.cnt2", 32'(bus2.mismatch_cnt), 32'd0);

        // Exhaustive sweep, one vector per cycle.
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            set_in(vecs[i].sel);
            tick();
            check8($sformatf("sweep%0d", i), vecs[i].s, vecs[i].co, 1'b0, 8'd0);
        end

        // Latency: inputs changed mid-cycle do not reach outputs before the edge.
        set_in(3'b000);
        tick();
        check8("lat0", 1'b0, 1'b0, 1'b0, 8'd0);
        #2;
        set_in(3'b111);
        #1;
        check8("lat_mid", 1'b0, 1'b0, 1'b0, 8'd0);
        tick();
        check8("lat1", 1'b1, 1'b1, 1'b0, 8'd0);

        // Fault in the case cell: sum stuck at 0 for three cycles on input 001.
        set_in(3'b001);
        force dut8.s_case = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            check($sformatf("fault%0d.mismatch", k), 32'(bus8.mismatch), 32'd1);
            check($sformatf("fault%0d.cnt", k), 32'(bus8.mismatch_cnt), 32'(k));
            check($sformatf("fault%0d.s3", k), 32'(bus8.s3), 32'd0);
            check($sformatf("fault%0d.s1", k), 32'(bus8.s1), 32'd1);
        end
        release dut8.s_case;
        tick();
        check8("fault_rel", 1'b1, 1'b0, 1'b0, 8'd3);
        check("fault_rel.cnt2", 32'(bus2.mismatch_cnt), 32'd0);

        // Saturation on the 2-bit counter: six faulty cycles.
        force dut2.s_case = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            check($sformatf("sat%0d.mismatch", k), 32'(bus2.mismatch), 32'd1);
            check($sformatf("sat%0d.cnt", k), 32'(bus2.mismatch_cnt), 32'((k < 3) ? k : 3));
        end
        release dut2.s_case;
        tick();
        check("sat_rel.mismatch", 32'(bus2.mismatch), 32'd0);
        check("sat_rel.cnt", 32'(bus2.mismatch_cnt), 32'd3);
        check8("sat_rel.dut8", 1'b1, 1'b0, 1'b0, 8'd3);

        // Mid-run reset clears results and counters.
        rst_n = 1'b0;
        set_in(3'b111);
        tick();
        check8("midrst", 1'b0, 1'b0, 1'b0, 8'd0);
        check("midrst.cnt2", 32'(bus2.mismatch_cnt), 32'd0);
        rst_n = 1'b1;
        set_in(3'b011);
        tick();
        check8("post_rst", 1'b0, 1'b1, 1'b0, 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_fa_triple
